// File: rtl/z16_pkg.sv
// z16_pkg
// Shared definitions for the Z16 decode stage:
//   - z16_op_e   : opcode encoding (0x0-0x9 ALU, 0xA LDI, 0xB ST; 0xC-0xF are illegal)
//   - *_LSB      : fixed instruction field positions
//   - z16_dec_t  : decoded-instruction record held by the stage register
//   - z16_decode : pure decode function used at capture time
package z16_pkg;

   localparam int FIELD_W = 4;
   localparam int OPC_LSB = 0;
   localparam int RD_LSB  = 4;
   localparam int RS1_LSB = 8;
   localparam int RS2_LSB = 12;

   typedef enum logic [3:0] {
      OP_ALU0 = 4'h0,
      OP_ALU1 = 4'h1,
      OP_ALU2 = 4'h2,
      OP_ALU3 = 4'h3,
      OP_ALU4 = 4'h4,
      OP_ALU5 = 4'h5,
      OP_ALU6 = 4'h6,
      OP_ALU7 = 4'h7,
      OP_ALU8 = 4'h8,
      OP_ALU9 = 4'h9,
      OP_LDI  = 4'hA,
      OP_ST   = 4'hB
   } z16_op_e;

   // The immediate is kept as the raw 4-bit nibble; the stage sign-extends it
   // to whatever datapath width it is built with.
   typedef struct packed {
      logic [3:0] opcode;
      logic [3:0] rd;
      logic [3:0] rs1;
      logic [3:0] rs2;
      logic [3:0] imm_nib;
      logic       rd_wen;
      logic       mem_wen;
      logic [3:0] alu_ctrl;
      logic       illegal;
      logic       use_rs1;
      logic       use_rs2;
   } z16_dec_t;

   // Register address fields are always passed through; whether they matter
   // is expressed by use_rs1/use_rs2/rd_wen, which drive the hazard check.
   function automatic z16_dec_t z16_decode(input logic [15:0] instr);
      z16_dec_t d;
      d         = '0;
      d.opcode  = instr[OPC_LSB +: FIELD_W];
      d.rd      = instr[RD_LSB  +: FIELD_W];
      d.rs1     = instr[RS1_LSB +: FIELD_W];
      d.rs2     = instr[RS2_LSB +: FIELD_W];
      case (instr[OPC_LSB +: FIELD_W])
         OP_ALU0, OP_ALU1, OP_ALU2, OP_ALU3, OP_ALU4,
         OP_ALU5, OP_ALU6, OP_ALU7, OP_ALU8, OP_ALU9: begin
            d.rd_wen   = 1'b1;
            d.alu_ctrl = instr[OPC_LSB +: FIELD_W];
            d.use_rs1  = 1'b1;
            d.use_rs2  = 1'b1;
         end
         OP_LDI: begin
            d.rd_wen   = 1'b1;
            d.imm_nib  = instr[RS2_LSB +: FIELD_W];
            d.use_rs1  = 1'b1;
         end
         OP_ST: begin
            d.mem_wen  = 1'b1;
            d.imm_nib  = instr[RD_LSB +: FIELD_W];
            d.use_rs1  = 1'b1;
            d.use_rs2  = 1'b1;
         end
         default: begin
            d.illegal  = 1'b1;
         end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/z16_scoreboard.sv
// z16_scoreboard
// Per-register pending-write scoreboard.
//   clk, rst_n        : clock, asynchronous active-low reset
//   set_en, set_addr  : mark a register busy (issued writer)
//   clr_en, clr_addr  : writeback completes, mark register free
//   rs1/rs2/rd_addr   : lookup addresses
//   rs1/rs2/rd_busy   : busy flags with same-cycle writeback bypass
module z16_scoreboard #(
   parameter int NREG = 16,
   localparam int AW  = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          set_en,
   input  logic [AW-1:0] set_addr,
   input  logic          clr_en,
   input  logic [AW-1:0] clr_addr,
   input  logic [AW-1:0] rs1_addr,
   input  logic [AW-1:0] rs2_addr,
   input  logic [AW-1:0] rd_addr,
   output logic          rs1_busy,
   output logic          rs2_busy,
   output logic          rd_busy
);

   logic [NREG-1:0] busy;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] clr_mask;
   logic [NREG-1:0] eff_busy;

   // One-hot masks for the set and clear requests of this cycle.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en) set_mask[set_addr] = 1'b1;
      if (clr_en) clr_mask[clr_addr] = 1'b1;
   end

   // A register being written back this cycle already counts as free.
   assign eff_busy = busy & ~clr_mask;

   assign rs1_busy = eff_busy[rs1_addr];
   assign rs2_busy = eff_busy[rs2_addr];
   assign rd_busy  = eff_busy[rd_addr];

   // Clear is applied first so a same-cycle set of the same register wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy <= (busy & ~clr_mask) | set_mask;
      end
   end

endmodule

// File: rtl/z16_decode_stage.sv
// z16_decode_stage
// Registered Z16 decode stage between fetch and execute with a pending-write
// scoreboard holding back issue on register hazards.
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_instr, i_valid, o_ready : fetch-side handshake
//   i_flush                   : drop the held instruction (redirect)
//   i_wb_valid, i_wb_addr     : writeback completion, frees a register
//   o_valid, i_ready          : execute-side handshake
//   o_opecode .. o_illegal    : decoded fields of the held instruction
// Optional macro Z16_DEC_STATS_EN adds saturating 32-bit o_issue_cnt and
// o_stall_cnt counters.
module z16_decode_stage
   import z16_pkg::*;
#(
   parameter int XLEN = 16,
   parameter int NREG = 16,
   parameter int ILEN = 16
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [ILEN-1:0] i_instr,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic            i_flush,
   input  logic            i_wb_valid,
   input  logic [3:0]      i_wb_addr,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [3:0]      o_opecode,
   output logic [3:0]      o_rd_addr,
   output logic [3:0]      o_rs1_addr,
   output logic [3:0]      o_rs2_addr,
   output logic [XLEN-1:0] o_imm,
   output logic            o_rd_wen,
   output logic            o_mem_wen,
   output logic [3:0]      o_alu_ctrl,
   output logic            o_illegal
`ifdef Z16_DEC_STATS_EN
   ,
   output logic [31:0]     o_issue_cnt,
   output logic [31:0]     o_stall_cnt
`endif
);

   localparam int AW = $clog2(NREG);

   z16_dec_t held;
   logic     held_valid;
   logic     rst_done;
   logic     rs1_busy;
   logic     rs2_busy;
   logic     rd_busy;
   logic     hazard;
   logic     fire;
   logic     accept;

   z16_scoreboard #(.NREG(NREG)) u_scoreboard (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .set_en   (fire & held.rd_wen),
      .set_addr (held.rd[AW-1:0]),
      .clr_en   (i_wb_valid),
      .clr_addr (i_wb_addr[AW-1:0]),
      .rs1_addr (held.rs1[AW-1:0]),
      .rs2_addr (held.rs2[AW-1:0]),
      .rd_addr  (held.rd[AW-1:0]),
      .rs1_busy (rs1_busy),
      .rs2_busy (rs2_busy),
      .rd_busy  (rd_busy)
   );

   assign hazard  = (held.use_rs1 & rs1_busy) |
                    (held.use_rs2 & rs2_busy) |
                    (held.rd_wen  & rd_busy);
   assign o_valid = held_valid & ~hazard;
   assign fire    = o_valid & i_ready;
   // rst_done keeps the stage closed until the first edge after reset release.
   assign o_ready = rst_done & ~i_flush & (~held_valid | fire);
   assign accept  = i_valid & o_ready;

   // Stage register: decoded fields only change on accept, so they stay
   // stable while execute back-pressures. Flush drops held_valid but a fire
   // in the same cycle still goes through on the combinational path.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         held_valid <= 1'b0;
         held       <= '0;
         rst_done   <= 1'b0;
      end else begin
         rst_done <= 1'b1;
         if (i_flush) begin
            held_valid <= 1'b0;
         end else if (accept) begin
            held_valid <= 1'b1;
         end else if (fire) begin
            held_valid <= 1'b0;
         end
         if (accept) begin
            held <= z16_decode(i_instr[15:0]);
         end
      end
   end

   assign o_opecode  = held.opcode;
   assign o_rd_addr  = held.rd;
   assign o_rs1_addr = held.rs1;
   assign o_rs2_addr = held.rs2;
   assign o_imm      = {{(XLEN-FIELD_W){held.imm_nib[FIELD_W-1]}}, held.imm_nib};
   assign o_rd_wen   = held.rd_wen;
   assign o_mem_wen  = held.mem_wen;
   assign o_alu_ctrl = held.alu_ctrl;
   assign o_illegal  = held.illegal;

`ifdef Z16_DEC_STATS_EN
   // Saturating issue and stall counters.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_issue_cnt <= '0;
         o_stall_cnt <= '0;
      end else begin
         if (fire && (o_issue_cnt != '1)) begin
            o_issue_cnt <= o_issue_cnt + 32'd1;
         end
         if (held_valid && hazard && (o_stall_cnt != '1)) begin
            o_stall_cnt <= o_stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_z16_decode_stage.sv
// tb_z16_decode_stage
// Directed bench for z16_decode_stage: reset, immediate decode, RAW hazard
// with writeback bypass, back-pressure, streaming, illegal opcodes, flush and
// asynchronous reset during a stall.
module tb_z16_decode_stage;

   logic        clk;
   logic        rst_n;
   logic [15:0] instr;
   logic        in_valid;
   logic        stage_ready;
   logic        flush;
   logic        wb_valid;
   logic [3:0]  wb_addr;
   logic        out_valid;
   logic        ex_ready;
   logic [3:0]  opcode;
   logic [3:0]  rd_addr;
   logic [3:0]  rs1_addr;
   logic [3:0]  rs2_addr;
   logic [15:0] imm;
   logic        rd_wen;
   logic        mem_wen;
   logic [3:0]  alu_ctrl;
   logic        illegal;
`ifdef Z16_DEC_STATS_EN
   logic [31:0] issue_cnt;
   logic [31:0] stall_cnt;
`endif

   int total = 0;
   int bad   = 0;

   z16_decode_stage #(.XLEN(16), .NREG(16), .ILEN(16)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_instr    (instr),
      .i_valid    (in_valid),
      .o_ready    (stage_ready),
      .i_flush    (flush),
      .i_wb_valid (wb_valid),
      .i_wb_addr  (wb_addr),
      .o_valid    (out_valid),
      .i_ready    (ex_ready),
      .o_opecode  (opcode),
      .o_rd_addr  (rd_addr),
      .o_rs1_addr (rs1_addr),
      .o_rs2_addr (rs2_addr),
      .o_imm      (imm),
      .o_rd_wen   (rd_wen),
      .o_mem_wen  (mem_wen),
      .o_alu_ctrl (alu_ctrl),
      .o_illegal  (illegal)
`ifdef Z16_DEC_STATS_EN
      ,
      .o_issue_cnt (issue_cnt),
      .o_stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      instr    = 16'h0000;
      in_valid = 1'b0;
      flush    = 1'b0;
      wb_valid = 1'b0;
      wb_addr  = 4'h0;
      ex_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #2;
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", out_valid); end
      total++; if (stage_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=0", stage_ready); end
      total++; if (imm !== 16'h0000) begin bad++; $display("[TB] FAIL reset_imm got=%h exp=0000", imm); end
      total++; if ({rd_addr, rd_wen, illegal} !== 6'b0) begin bad++; $display("[TB] FAIL reset_fields got=%h exp=00", {rd_addr, rd_wen, illegal}); end
      step();
      rst_n = 1'b1;
      #1;
      total++; if (stage_ready !== 1'b0) begin bad++; $display("[TB] FAIL release_ready_early got=%b exp=0", stage_ready); end
      step();
      total++; if (stage_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_ready got=%b exp=1", stage_ready); end
   endtask

   task automatic test_ldi();
      instr = 16'h321A; in_valid = 1'b1; ex_ready = 1'b0;
      #1;
      total++; if (stage_ready !== 1'b1) begin bad++; $display("[TB] FAIL ldi_accept_ready got=%b exp=1", stage_ready); end
      step();
      in_valid = 1'b0;
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL ldi_valid got=%b exp=1", out_valid); end
      total++; if (rd_addr !== 4'h1) begin bad++; $display("[TB] FAIL ldi_rd got=%h exp=1", rd_addr); end
      total++; if (rs1_addr !== 4'h2) begin bad++; $display("[TB] FAIL ldi_rs1 got=%h exp=2", rs1_addr); end
      total++; if (imm !== 16'h0003) begin bad++; $display("[TB] FAIL ldi_imm got=%h exp=0003", imm); end
      total++; if ({rd_wen, mem_wen, opcode, alu_ctrl} !== 10'b1_0_1010_0000) begin bad++; $display("[TB] FAIL ldi_ctrl got=%b exp=1010100000", {rd_wen, mem_wen, opcode, alu_ctrl}); end
      total++; if (stage_ready !== 1'b0) begin bad++; $display("[TB] FAIL ldi_hold_ready got=%b exp=0", stage_ready); end
      // Issue it and accept the negative-immediate variant in the same cycle.
      ex_ready = 1'b1; in_valid = 1'b1; instr = 16'hF21A;
      #1;
      total++; if (stage_ready !== 1'b1) begin bad++; $display("[TB] FAIL ldi_b2b_ready got=%b exp=1", stage_ready); end
      step();
      in_valid = 1'b0;
      #1;
      total++; if (imm !== 16'hFFFF) begin bad++; $display("[TB] FAIL ldi_neg_imm got=%h exp=FFFF", imm); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL ldi_rd_hazard got=%b exp=0", out_valid); end
      // Writeback of r1 in the same cycle bypasses the hazard; the reissue
      // sets busy[1] again because set wins over clear.
      wb_valid = 1'b1; wb_addr = 4'h1;
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL ldi_bypass got=%b exp=1", out_valid); end
      step();
      wb_valid = 1'b0; in_valid = 1'b1; instr = 16'h0011;
      step();
      in_valid = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL set_wins got=%b exp=0", out_valid); end
      do_reset();
   endtask

   task automatic test_hazard();
      instr = 16'h0213; in_valid = 1'b1; ex_ready = 1'b1;
      step();
      instr = 16'h1324;
      #1;
      total++; if ({out_valid, alu_ctrl} !== 5'b1_0011) begin bad++; $display("[TB] FAIL haz_first got=%b exp=10011", {out_valid, alu_ctrl}); end
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL haz_stall%0d got=%b exp=0", i, out_valid); end
         step();
      end
      wb_valid = 1'b1; wb_addr = 4'h1;
      #1;
      total++; if ({out_valid, opcode} !== 5'b1_0100) begin bad++; $display("[TB] FAIL haz_wb_issue got=%b exp=10100", {out_valid, opcode}); end
      step();
      wb_valid = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL haz_drained got=%b exp=0", out_valid); end
      do_reset();
   endtask

   task automatic test_backpressure();
      instr = 16'h00AB; in_valid = 1'b1; ex_ready = 1'b0;
      step();
      instr = 16'h0001;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid%0d got=%b exp=1", i, out_valid); end
         total++; if ({imm, mem_wen, rd_wen} !== {16'hFFFA, 2'b10}) begin bad++; $display("[TB] FAIL bp_fields%0d got=%h exp=%h", i, {imm, mem_wen, rd_wen}, {16'hFFFA, 2'b10}); end
         total++; if (stage_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready%0d got=%b exp=0", i, stage_ready); end
         step();
      end
      ex_ready = 1'b1;
      #1;
      total++; if ({out_valid, stage_ready} !== 2'b11) begin bad++; $display("[TB] FAIL bp_release got=%b exp=11", {out_valid, stage_ready}); end
      step();
      in_valid = 1'b0;
      #1;
      total++; if ({out_valid, opcode} !== 5'b1_0001) begin bad++; $display("[TB] FAIL bp_next got=%b exp=10001", {out_valid, opcode}); end
      do_reset();
   endtask

   task automatic test_back_to_back();
      int fires;
      fires = 0;
      ex_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         in_valid = (i < 8);
         instr    = {8'h00, 4'(i + 8), 4'(i + 2)};
         #1;
         if (i > 0) begin
            total++; if ({out_valid, alu_ctrl} !== {1'b1, 4'(i + 1)}) begin bad++; $display("[TB] FAIL b2b_issue%0d got=%b exp=%b", i, {out_valid, alu_ctrl}, {1'b1, 4'(i + 1)}); end
            if (out_valid && ex_ready) fires++;
         end
         step();
      end
      total++; if (fires != 8) begin bad++; $display("[TB] FAIL b2b_fires got=%0d exp=8", fires); end
      do_reset();
   endtask

   task automatic test_illegal();
      instr = 16'h001E; in_valid = 1'b1; ex_ready = 1'b1;
      step();
      instr = 16'h0015;
      #1;
      total++; if ({out_valid, illegal, rd_wen, mem_wen} !== 4'b1100) begin bad++; $display("[TB] FAIL ill_flags got=%b exp=1100", {out_valid, illegal, rd_wen, mem_wen}); end
      total++; if (imm !== 16'h0000) begin bad++; $display("[TB] FAIL ill_imm got=%h exp=0000", imm); end
      step();
      in_valid = 1'b0;
      #1;
      total++; if ({out_valid, illegal} !== 2'b10) begin bad++; $display("[TB] FAIL ill_no_busy got=%b exp=10", {out_valid, illegal}); end
      do_reset();
   endtask

   task automatic test_flush_reset();
      instr = 16'h0213; in_valid = 1'b1; ex_ready = 1'b1;
      step();
      instr = 16'h1324;
      step();
      in_valid = 1'b0;
      flush = 1'b1;
      #1;
      total++; if ({out_valid, stage_ready} !== 2'b00) begin bad++; $display("[TB] FAIL flush_cycle got=%b exp=00", {out_valid, stage_ready}); end
      step();
      flush = 1'b0;
      #1;
      total++; if ({out_valid, stage_ready} !== 2'b01) begin bad++; $display("[TB] FAIL flush_cleared got=%b exp=01", {out_valid, stage_ready}); end
      // Scoreboard survives the flush: r1 is still pending.
      instr = 16'h0011; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_keeps_busy got=%b exp=0", out_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if ({out_valid, stage_ready, rd_wen, rd_addr} !== 7'b0) begin bad++; $display("[TB] FAIL async_reset got=%b exp=0000000", {out_valid, stage_ready, rd_wen, rd_addr}); end
      step();
      rst_n = 1'b1;
      step();
      instr = 16'h0011; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL reset_clears_busy got=%b exp=1", out_valid); end
      do_reset();
   endtask

   initial begin
      test_reset();
      test_ldi();
      test_hazard();
      test_backpressure();
      test_back_to_back();
      test_illegal();
      test_flush_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
